// File: rtl/octal_to_binary.sv
// Registered 8-to-3 one-hot encoder with valid/err flags; optional macro OCTAL_TO_BINARY_PRIORITY_EN selects priority encoding of multi-hot inputs.
// Latency: 1 cycle from sampled o to b/valid/err.
// Backpressure: none; en=0 holds all outputs, one code per cycle otherwise.
module octal_to_binary (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] o,
    output logic [2:0] b,
    output logic       valid,
    output logic       err
);

    logic [2:0] b_q, b_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;

    logic [3:0] hot_cnt;
    logic [2:0] top_idx;
    logic       one_hot;
    logic       multi_hot;

    // Highest set bit doubles as the index of the only set bit when one-hot.
    always_comb begin
        hot_cnt = 4'd0;
        top_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (o[i]) begin
                hot_cnt = hot_cnt + 4'd1;
                top_idx = 3'(i);
            end
        end
    end

    assign one_hot   = (hot_cnt == 4'd1);
    assign multi_hot = (hot_cnt > 4'd1);

    always_comb begin
        b_d     = b_q;
        valid_d = valid_q;
        err_d   = err_q;
        if (en) begin
            err_d = multi_hot;
            if (one_hot) begin
                b_d     = top_idx;
                valid_d = 1'b1;
            end else if (multi_hot) begin
`ifdef OCTAL_TO_BINARY_PRIORITY_EN
                b_d     = top_idx;
                valid_d = 1'b1;
`else
                b_d     = 3'd0;
                valid_d = 1'b0;
`endif
            end else begin
                b_d     = 3'd0;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_q     <= 3'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            b_q     <= b_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign b     = b_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule

// File: tb/tb_octal_to_binary.sv
// Directed bench for octal_to_binary; expected values hand-computed, build-dependent ones follow OCTAL_TO_BINARY_PRIORITY_EN.
module tb_octal_to_binary;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] o;
    logic [2:0] b;
    logic       valid;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;

    octal_to_binary dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .o     (o),
        .b     (b),
        .valid (valid),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic cycle(input logic r, input logic e, input logic [7:0] ov);
        @(negedge clk);
        rst = r;
        en  = e;
        o   = ov;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [2:0] eb,
                              input logic ev, input logic ee);
        chk({tag, ".b"},     {5'd0, b},     {5'd0, eb});
        chk({tag, ".valid"}, {7'd0, valid}, {7'd0, ev});
        chk({tag, ".err"},   {7'd0, err},   {7'd0, ee});
    endtask

    logic [7:0] sweep [8];
    logic [2:0] mh_b;
    logic       mh_v;
    logic [2:0] ff_b;

    initial begin
        sweep = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
`ifdef OCTAL_TO_BINARY_PRIORITY_EN
        mh_b = 3'd5; mh_v = 1'b1; ff_b = 3'd7;
`else
        mh_b = 3'd0; mh_v = 1'b0; ff_b = 3'd0;
`endif
        rst = 1'b1;
        en  = 1'b1;
        o   = 8'hFF;

        cycle(1'b1, 1'b1, 8'hFF);
        expect_out("reset", 3'd0, 1'b0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b1, sweep[k]);
            expect_out($sformatf("sweep%0d", k), 3'(k), 1'b1, 1'b0);
        end

        cycle(1'b0, 1'b1, 8'h00);
        expect_out("zero", 3'd0, 1'b0, 1'b0);

        cycle(1'b0, 1'b1, 8'h28);
        expect_out("multi28", mh_b, mh_v, 1'b1);

        cycle(1'b0, 1'b1, 8'hFF);
        expect_out("multiFF", ff_b, mh_v, 1'b1);

        cycle(1'b0, 1'b1, 8'h40);
        expect_out("hold_pre", 3'd6, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 8'h02);
            expect_out($sformatf("hold%0d", k), 3'd6, 1'b1, 1'b0);
        end
        cycle(1'b0, 1'b1, 8'h02);
        expect_out("hold_rel", 3'd1, 1'b1, 1'b0);

        // Hold an error state, then confirm en=0 does not clear it.
        cycle(1'b0, 1'b1, 8'h28);
        cycle(1'b0, 1'b0, 8'h01);
        expect_out("hold_err", mh_b, mh_v, 1'b1);

        cycle(1'b0, 1'b1, 8'h10);
        expect_out("stream_a", 3'd4, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 8'h20);
        expect_out("rst_pulse", 3'd0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h08);
        expect_out("post_rst", 3'd3, 1'b1, 1'b0);

        // Reset wins over en=0.
        cycle(1'b1, 1'b0, 8'h80);
        expect_out("rst_over_en", 3'd0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h80);
        expect_out("after_rst", 3'd7, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
